// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame state encoding
// and divisor/count clamping helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_t;

  localparam logic [15:0] UART_DIV_MIN = 16'd2;

  function automatic logic [15:0] uart_div_eff(input logic [15:0] div);
    return (div < UART_DIV_MIN) ? UART_DIV_MIN : div;
  endfunction

  // Bit and stop counts of 0 behave as 1.
  function automatic logic [3:0] uart_count_eff(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for asynchronous pins, with a selectable
// reset value so idle-high lines do not glitch out of reset.
module sync_ff #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RESET_VALUE}};
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, samples each bit at its centre and presents
// the word with parity/framing flags on a one-cycle strobe.
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronised line
//   START  | counting to mid start bit to confirm it is still low
//   DATA   | sampling bit_count data bits, LSB first
//   PARITY | sampling and checking the parity bit
//   STOP   | sampling stop bits; strobe after the last one
import uart_pkg::*;

module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        parity_enable,
  input  logic        parity_odd_n_even,
  input  logic [3:0]  bit_count,
  input  logic [3:0]  stop_count,
  input  logic        rx,
  output logic [15:0] data,
  output logic        parity_error,
  output logic        framing_error,
  output logic        strobe_received,
  output logic        busy
);

  uart_state_t state, state_next;

  logic        rx_s, rx_prev;
  logic [15:0] div_eff, div_q, count;
  logic        par_en_q, par_odd_q;
  logic [3:0]  bits_q, stops_q, idx;
  logic [15:0] shift;
  logic        par_acc, par_err_p, frm_err_p;
  logic        start_edge, sample, last_data, last_stop;

  sync_ff #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign div_eff    = uart_div_eff(div);
  assign start_edge = !rx_s && rx_prev;
  assign sample     = (count == 16'd0);
  assign last_data  = (idx == bits_q - 4'd1);
  assign last_stop  = (idx == stops_q - 4'd1);
  assign busy       = (state != UART_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UART_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      UART_IDLE:   if (start_edge) state_next = UART_START;
      UART_START:  if (sample) state_next = rx_s ? UART_IDLE : UART_DATA;
      UART_DATA:   if (sample && last_data) state_next = par_en_q ? UART_PARITY : UART_STOP;
      UART_PARITY: if (sample) state_next = UART_STOP;
      UART_STOP:   if (sample && last_stop) state_next = UART_IDLE;
      default:     state_next = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev         <= 1'b1;
      div_q           <= UART_DIV_MIN;
      count           <= 16'd0;
      par_en_q        <= 1'b0;
      par_odd_q       <= 1'b0;
      bits_q          <= 4'd1;
      stops_q         <= 4'd1;
      idx             <= 4'd0;
      shift           <= 16'd0;
      par_acc         <= 1'b0;
      par_err_p       <= 1'b0;
      frm_err_p       <= 1'b0;
      data            <= 16'd0;
      parity_error    <= 1'b0;
      framing_error   <= 1'b0;
      strobe_received <= 1'b0;
    end else begin
      rx_prev         <= rx_s;
      strobe_received <= 1'b0;
      if (state == UART_IDLE) begin
        // Configuration is frozen for the whole frame from here on.
        if (start_edge) begin
          div_q     <= div_eff;
          count     <= (div_eff >> 1) - 16'd1;
          par_en_q  <= parity_enable;
          par_odd_q <= parity_odd_n_even;
          bits_q    <= uart_count_eff(bit_count);
          stops_q   <= uart_count_eff(stop_count);
          idx       <= 4'd0;
        end
      end else begin
        count <= sample ? div_q - 16'd1 : count - 16'd1;
        if (sample) begin
          case (state)
            UART_START: begin
              shift     <= 16'd0;
              par_acc   <= 1'b0;
              par_err_p <= 1'b0;
              frm_err_p <= 1'b0;
              idx       <= 4'd0;
            end
            UART_DATA: begin
              shift[idx] <= rx_s;
              par_acc    <= par_acc ^ rx_s;
              idx        <= last_data ? 4'd0 : idx + 4'd1;
            end
            UART_PARITY: par_err_p <= (rx_s != (par_odd_q ^ par_acc));
            UART_STOP: begin
              frm_err_p <= frm_err_p | !rx_s;
              idx       <= idx + 4'd1;
              // Leaving at mid stop bit leaves half a bit to catch the next start edge.
              if (last_stop) begin
                data            <= shift;
                parity_error    <= par_err_p;
                framing_error   <= frm_err_p | !rx_s;
                strobe_received <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames, hand-written
// break/glitch/reset sequences, and randomized frames against a frame-level model.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div = 16'd16;
  logic        parity_enable = 1'b0;
  logic        parity_odd_n_even = 1'b0;
  logic [3:0]  bit_count = 4'd8;
  logic [3:0]  stop_count = 4'd1;
  logic        rx = 1'b1;
  logic [15:0] data;
  logic        parity_error, framing_error, strobe_received, busy;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .div               (div),
    .parity_enable     (parity_enable),
    .parity_odd_n_even (parity_odd_n_even),
    .bit_count         (bit_count),
    .stop_count        (stop_count),
    .rx                (rx),
    .data              (data),
    .parity_error      (parity_error),
    .framing_error     (framing_error),
    .strobe_received   (strobe_received),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    logic        busy;
  } obs_t;

  typedef struct {
    logic [15:0] div;
    logic [3:0]  bits;
    logic        pe;
    logic        po;
    logic [3:0]  stops;
    logic [15:0] word;
    logic        flip;
    logic [15:0] stop_low;
    int          gap;
  } frame_t;

  typedef struct {
    frame_t      f;
    logic [15:0] exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  obs_t got_q[$];
  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (strobe_received) begin
      obs_t o;
      o.cyc  = cyc;
      o.data = data;
      o.perr = parity_error;
      o.ferr = framing_error;
      o.busy = busy;
      got_q.push_back(o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic frame_t mkf(input logic [15:0] d, input logic [3:0] nb, input logic pe,
                                 input logic po, input logic [3:0] ns, input logic [15:0] w,
                                 input logic fl, input logic [15:0] sl, input int gap);
    frame_t f;
    f.div = d; f.bits = nb; f.pe = pe; f.po = po; f.stops = ns;
    f.word = w; f.flip = fl; f.stop_low = sl; f.gap = gap;
    return f;
  endfunction

  function automatic vec_t mkv(input frame_t f, input logic [15:0] ed, input logic ep, input logic ef);
    vec_t v;
    v.f = f; v.exp_data = ed; v.exp_perr = ep; v.exp_ferr = ef;
    return v;
  endfunction

  // Serial transmitter; must be entered 1 time unit after a rising edge.
  // gap = 0 leaves the line at the last stop level (used for break).
  task automatic send_frame(input frame_t f, output int e0);
    int de, nb, ns;
    logic [15:0] d;
    de = (f.div < 16'd2) ? 2 : int'(f.div);
    nb = (f.bits == 4'd0) ? 1 : int'(f.bits);
    ns = (f.stops == 4'd0) ? 1 : int'(f.stops);
    d = '0;
    for (int i = 0; i < nb; i++) d[i] = f.word[i];
    div = f.div; bit_count = f.bits; stop_count = f.stops;
    parity_enable = f.pe; parity_odd_n_even = f.po;
    e0 = cyc;
    rx = 1'b0; hold(de);
    for (int i = 0; i < nb; i++) begin rx = d[i]; hold(de); end
    if (f.pe) begin rx = f.po ^ (^d) ^ f.flip; hold(de); end
    for (int i = 0; i < ns; i++) begin rx = !f.stop_low[i]; hold(de); end
    if (f.gap > 0) begin rx = 1'b1; hold(f.gap); end
  endtask

  // Frame-level reference: what the receiver must report and when. The start
  // edge reaches the FSM 3 edges after the line falls (2 sync flops + edge detect).
  function automatic obs_t model(input frame_t f, input int e0);
    obs_t o;
    int de, nb, np, ns, ones, wire_par;
    de = (f.div < 16'd2) ? 2 : int'(f.div);
    nb = (f.bits == 4'd0) ? 1 : int'(f.bits);
    ns = (f.stops == 4'd0) ? 1 : int'(f.stops);
    np = f.pe ? 1 : 0;
    o.data = '0;
    for (int i = 0; i < nb; i++) o.data[i] = f.word[i];
    ones = $countones(o.data);
    wire_par = ((f.po ? 1 : 0) + ones + (f.flip ? 1 : 0)) % 2;
    o.perr = f.pe && (((ones + wire_par) % 2) != (f.po ? 1 : 0));
    o.ferr = 1'b0;
    for (int i = 0; i < ns; i++) if (f.stop_low[i]) o.ferr = 1'b1;
    o.cyc  = e0 + 3 + de / 2 + (nb + np + ns) * de;
    o.busy = 1'b0;
    return o;
  endfunction

  task automatic check_frames(input string tag);
    hold(60);
    chk({tag, " strobe count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s[%0d] cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s[%0d] data", tag, i), {16'd0, got_q[i].data}, {16'd0, exp_q[i].data});
      chk($sformatf("%s[%0d] parity_error", tag, i), {31'd0, got_q[i].perr}, {31'd0, exp_q[i].perr});
      chk($sformatf("%s[%0d] framing_error", tag, i), {31'd0, got_q[i].ferr}, {31'd0, exp_q[i].ferr});
      chk($sformatf("%s[%0d] busy at strobe", tag, i), {31'd0, got_q[i].busy}, 32'd0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " data"}, {16'd0, data}, 32'd0);
    chk({tag, " parity_error"}, {31'd0, parity_error}, 32'd0);
    chk({tag, " framing_error"}, {31'd0, framing_error}, 32'd0);
    chk({tag, " strobe"}, {31'd0, strobe_received}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t   vt[8];
    frame_t f;
    obs_t   o;
    int     e0, ns, k;

    vt[0] = mkv(mkf(16'd16, 4'd8,  1'b0, 1'b0, 4'd1, 16'h00A5, 1'b0, 16'h0, 0), 16'h00A5, 1'b0, 1'b0);
    vt[1] = mkv(mkf(16'd10, 4'd7,  1'b1, 1'b1, 4'd2, 16'h005A, 1'b0, 16'h0, 0), 16'h005A, 1'b0, 1'b0);
    vt[2] = mkv(mkf(16'd10, 4'd7,  1'b1, 1'b1, 4'd2, 16'h005A, 1'b1, 16'h0, 0), 16'h005A, 1'b1, 1'b0);
    vt[3] = mkv(mkf(16'd16, 4'd8,  1'b0, 1'b0, 4'd1, 16'h0096, 1'b0, 16'h1, 3), 16'h0096, 1'b0, 1'b1);
    vt[4] = mkv(mkf(16'd12, 4'd15, 1'b1, 1'b0, 4'd1, 16'h7FFF, 1'b0, 16'h0, 0), 16'h7FFF, 1'b0, 1'b0);
    vt[5] = mkv(mkf(16'd12, 4'd15, 1'b1, 1'b0, 4'd1, 16'h0001, 1'b0, 16'h0, 0), 16'h0001, 1'b0, 1'b0);
    vt[6] = mkv(mkf(16'd0,  4'd0,  1'b0, 1'b0, 4'd0, 16'hFFFF, 1'b0, 16'h0, 0), 16'h0001, 1'b0, 1'b0);
    vt[7] = mkv(mkf(16'd3,  4'd4,  1'b1, 1'b1, 4'd3, 16'hABCD, 1'b0, 16'h2, 0), 16'h000D, 1'b0, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    hold(5);

    // Directed frames, mostly back-to-back
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].f, e0);
      o = model(vt[i].f, e0);
      o.data = vt[i].exp_data;
      o.perr = vt[i].exp_perr;
      o.ferr = vt[i].exp_ferr;
      exp_q.push_back(o);
    end
    rx = 1'b1;
    check_frames("vec");

    // Framing error followed by a held-low break: only one strobe
    f = mkf(16'd16, 4'd8, 1'b0, 1'b0, 4'd1, 16'h000F, 1'b0, 16'h1, 0);
    send_frame(f, e0);
    exp_q.push_back(model(f, e0));
    check_frames("break");
    rx = 1'b1;
    hold(2);
    f = mkf(16'd16, 4'd8, 1'b0, 1'b0, 4'd1, 16'h003C, 1'b0, 16'h0, 2);
    send_frame(f, e0);
    exp_q.push_back(model(f, e0));
    check_frames("after_break");

    // 5-cycle glitch is rejected at the start-bit centre
    div = 16'd16; bit_count = 4'd8; stop_count = 4'd1; parity_enable = 1'b0;
    k = cyc;
    rx = 1'b0;
    hold(4);
    @(negedge clk);
    chk("glitch busy after T0", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rx = 1'b1;
    hold(k + 11 - cyc);
    @(negedge clk);
    chk("glitch busy cleared by T0+8", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_frames("glitch");

    // Reset in the middle of DATA
    rx = 1'b0; hold(16);
    rx = 1'b1; hold(16);
    rx = 1'b0; hold(8);
    rst = 1'b1;
    hold(2);
    @(negedge clk);
    check_reset_outputs("midframe reset");
    @(posedge clk); #1;
    rx = 1'b1;
    hold(2);
    rst = 1'b0;
    hold(2);
    f = mkf(16'd16, 4'd8, 1'b0, 1'b0, 4'd1, 16'h003C, 1'b0, 16'h0, 2);
    send_frame(f, e0);
    exp_q.push_back(model(f, e0));
    check_frames("post_reset");

    // Randomized frames with configuration changing between frames
    for (int n = 0; n < 24; n++) begin
      f.div   = 16'($urandom_range(0, 20));
      f.bits  = 4'($urandom_range(0, 15));
      f.pe    = 1'($urandom_range(0, 1));
      f.po    = 1'($urandom_range(0, 1));
      f.stops = 4'($urandom_range(0, 3));
      f.word  = 16'($urandom_range(0, 65535));
      f.flip  = f.pe && ($urandom_range(0, 3) == 0);
      ns = (f.stops == 4'd0) ? 1 : int'(f.stops);
      f.stop_low = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, (1 << ns) - 1)) : 16'h0;
      f.gap = f.stop_low[ns-1] ? 2 : 5 * int'($urandom_range(0, 1));
      send_frame(f, e0);
      exp_q.push_back(model(f, e0));
    end
    rx = 1'b1;
    check_frames("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the downstream counterpart of the UART transmitter, sharing its frame configuration so a tx/rx pair loops back cleanly. It synchronises the asynchronous `rx` pin and validates the start bit at mid-bit. It samples data, optional parity and stop bits at bit centres, then presents the assembled word with error flags on a one-cycle strobe.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flops in the `rx` synchroniser; legal values are 2 or more.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `div`  in  16  baud divisor, baud = clk / div; values below 2 are treated as 2.
- `parity_enable`  in  1  1 = a parity bit follows the data.
- `parity_odd_n_even`  in  1  1 = odd parity expected, 0 = even.
- `bit_count`  in  4  data bits per frame, 1 to 15; 0 is treated as 1.
- `stop_count`  in  4  stop bits per frame, 1 to 15; 0 is treated as 1.
- `rx`  in  1  serial input pin; asynchronous to `clk`, idles high.
- `data`  out  16  received word; first bit received lands in `data[0]`; bits at and above `bit_count` are 0.
- `parity_error`  out  1  parity mismatch on the frame just completed.
- `framing_error`  out  1  at least one stop bit sampled low.
- `strobe_received`  out  1  one-cycle pulse; `data` and both error flags are valid in this cycle.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on the synchronised line (`rx_s` = 0, previous `rx_s` = 1) does the following:
  - latch all configuration inputs;
  - load `half` = `div`>>1 and set `count` = `half`−1;
  - go to START.
- A line held low (break) produces no new frame until it returns high.
- Sampling counter, outside IDLE: on each sample cycle (`count` = 0) reload `count` = `div`−1; otherwise decrement `count`.
- START sample:
  - `rx_s` = 1 means a false start: go to IDLE with no strobe.
  - `rx_s` = 0 means the start bit is valid: clear the shift register, go to DATA.
- DATA: each sample writes `rx_s` into bit position i (i = 0 .. bit_count−1) and folds it into the running parity. After the last data bit go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: expected bit = `parity_odd_n_even` XOR (XOR of the data bits), matching the transmitter. A mismatch sets the pending parity error. Then go to STOP.
- STOP: each sample ORs (NOT `rx_s`) into the pending framing error. After the last stop sample:
  - update `data`, `parity_error` and `framing_error`;
  - pulse `strobe_received`;
  - go to IDLE.
  The return to IDLE happens at mid-stop-bit so a following start edge is caught.
- Configuration changes while `busy` = 1 have no effect until the next frame.
- `data` and the error flags hold their values until the next strobe. There is no back-pressure; the consumer must capture on the strobe.

## Timing
- Reset values: `data` = 0, `parity_error` = 0, `framing_error` = 0, `strobe_received` = 0, `busy` = 0, state IDLE, synchroniser flops = 1.
- Synchroniser delay: `rx` to `rx_s` is `SYNC_STAGES` cycles.
- Let T0 be the clock edge at which IDLE detects the edge; `busy` = 1 from the cycle after T0.
- Start sample at edge T0+`half`; sample k (start = 0) at T0+`half`+k·`div`.
- Final stop sample at T0+`half`+(N+P+S)·`div`, where N = data bits, P = 1 if parity is enabled (else 0), S = stop bits.
- `strobe_received` is high in the cycle after the final stop sample; `busy` is 0 in that same cycle.
- A start edge detected in the strobe cycle begins the next frame. The back-to-back gap is zero.
- `rst` asserted mid-frame clears everything immediately, with no strobe. Sampling resumes on the first falling edge after `rst` deasserts.

## Structure
- Shared package `uart_pkg`: state encodings common to the tx and rx blocks, plus the minimum-divisor constant (2). The transmitter migrates to it.
- One sub-module, `sync_ff`: an N-stage single-bit synchroniser with configurable reset value (1 here). It is reused for other asynchronous pins.

## Test plan
- `div`=16, 8N1, drive 0xA5 through `uart_tx` in loopback:
  - `strobe_received` fires once;
  - `data` = 0x00A5, both error flags 0;
  - strobe at T0+8+9·16.
- `div`=10, 7 bits, odd parity, 2 stop bits, word 0x5A:
  - `data` = 0x005A, `parity_error` = 0;
  - repeat with the parity bit forced inverted: `parity_error` = 1, `data` unchanged.
- `div`=16, 8N1, stop bit driven 0: `framing_error` = 1. Hold `rx` low 40 cycles afterwards (break): no second strobe until `rx` rises and falls again.
- `div`=16, `rx` low for 5 cycles only (glitch): no strobe, `busy` returns to 0 within 8 cycles of T0.
- 15 bits, even parity, 1 stop, two back-to-back frames 0x7FFF and 0x0001 from `uart_tx`: two strobes, correct data, no errors.
- Assert `rst` mid-DATA of a frame: outputs at reset values, no strobe. The next full frame (0x3C) is received correctly.
